// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer.
// An empty stage always presents BUBBLE_VAL; flush squashes the stage into a bubble.
module pipe_stage_reg #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      BUBBLE_VAL = 32'h0000_0013,
  parameter bit                    SKID       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_nextMain;
  logic [WIDTH-1:0] w_nextSkid;
  logic             w_accept;
  logic             w_deliver;

  assign out_valid = (r_state != EMPTY);
  assign out_data  = out_valid ? r_main : BUBBLE_VAL;
  assign count     = r_state;

  // The skid variant derives ready purely from state to break the out_ready -> in_ready path.
  assign in_ready  = SKID ? (r_state != TWO) : (~out_valid | out_ready);

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else begin
      r_state <= w_nextState;
      r_main  <= w_nextMain;
      r_skid  <= w_nextSkid;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextMain  = r_main;
    w_nextSkid  = r_skid;
    if (flush) begin
      w_nextState = EMPTY;
      w_nextMain  = BUBBLE_VAL;
      w_nextSkid  = BUBBLE_VAL;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_nextMain  = in_data;
            w_nextState = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_deliver) begin
            w_nextMain = in_data;
          end else if (w_accept && SKID) begin
            w_nextSkid  = in_data;
            w_nextState = TWO;
          end else if (w_deliver) begin
            w_nextMain  = BUBBLE_VAL;
            w_nextState = EMPTY;
          end
        end
        TWO: begin
          if (w_deliver) begin
            w_nextMain  = r_skid;
            w_nextSkid  = BUBBLE_VAL;
            w_nextState = ONE;
          end
        end
        default: begin
          w_nextState = EMPTY;
          w_nextMain  = BUBBLE_VAL;
          w_nextSkid  = BUBBLE_VAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default skid stage and a 7-bit single-entry stage.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        flush1, inV1, inR1, outV1, outR1;
  logic [31:0] inD1, outD1;
  logic [1:0]  cnt1;

  logic        flush0, inV0, inR0, outV0, outR0;
  logic [6:0]  inD0, outD0;
  logic [1:0]  cnt0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_skid (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(inV1), .in_data(inD1), .in_ready(inR1),
    .out_valid(outV1), .out_data(outD1), .out_ready(outR1), .count(cnt1)
  );

  pipe_stage_reg #(.WIDTH(7), .BUBBLE_VAL(7'b0010011), .SKID(1'b0)) u_single (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(inV0), .in_data(inD0), .in_ready(inR0),
    .out_valid(outV0), .out_data(outD0), .out_ready(outR0), .count(cnt0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    inV1   = v;
    inD1   = d;
    outR1  = r;
    flush1 = f;
  endtask

  task automatic checkSkid(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic rdy);
    checkOutput({tag, "_valid"}, {31'd0, outV1}, {31'd0, v});
    checkOutput({tag, "_data"},  outD1, d);
    checkOutput({tag, "_count"}, {30'd0, cnt1}, {30'd0, c});
    checkOutput({tag, "_ready"}, {31'd0, inR1}, {31'd0, rdy});
  endtask

  logic [19:0] readyPat;
  logic [19:0] validPat;
  logic        expValid;
  logic [6:0]  expHead;
  logic        expAcc;

  initial begin
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    flush0 = 1'b0; inV0 = 1'b0; inD0 = 7'd0; outR0 = 1'b0;

    // Reset state of both stages
    #2;
    checkSkid("rst", 1'b0, 32'h13, 2'd0, 1'b1);
    checkOutput("rst0_valid", {31'd0, outV0}, 32'd0);
    checkOutput("rst0_data",  {25'd0, outD0}, 32'h13);
    checkOutput("rst0_ready", {31'd0, inR0},  32'd1);
    tick();
    rst = 1'b1;

    // Streaming 1..16 at full throughput
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, i, 1'b1, 1'b0);
      tick();
      checkSkid($sformatf("stream%0d", i), 1'b1, i, 2'd1, 1'b1);
    end

    // Idle head: last payload delivered with nothing behind it
    applyStimulus(1'b0, 32'hDEAD, 1'b1, 1'b0);
    tick();
    checkSkid("idle", 1'b0, 32'h13, 2'd0, 1'b1);

    // Backpressure: 1 at head, out_ready drops, 2 absorbed into skid, 3 held
    applyStimulus(1'b1, 32'd1, 1'b1, 1'b0);
    tick();
    checkSkid("bp_head1", 1'b1, 32'd1, 2'd1, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready_before_skid", {31'd0, inR1}, 32'd1);
    tick();
    checkSkid("bp_full", 1'b1, 32'd1, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0);
    tick();
    checkSkid("bp_hold", 1'b1, 32'd1, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'd3, 1'b1, 1'b0);
    tick();
    checkSkid("bp_rel2", 1'b1, 32'd2, 2'd1, 1'b1);
    tick();
    checkSkid("bp_rel3", 1'b1, 32'd3, 2'd1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    checkSkid("bp_drain", 1'b0, 32'h13, 2'd0, 1'b1);

    // Flush with two held, a delivery and an accept in the same cycle
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    checkSkid("fl_full", 1'b1, 32'h10, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b1, 1'b1);
    #1;
    checkOutput("fl_deliver", outD1, 32'h10);
    tick();
    checkSkid("fl_after", 1'b0, 32'h13, 2'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkSkid("fl_empty", 1'b0, 32'h13, 2'd0, 1'b1);

    // Asynchronous reset while full
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    tick();
    checkSkid("mr_full", 1'b1, 32'hAAAA_0001, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkSkid("mr_async", 1'b0, 32'h13, 2'd0, 1'b1);
    tick();
    checkSkid("mr_held", 1'b0, 32'h13, 2'd0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    checkSkid("mr_first", 1'b1, 32'h1234_5678, 2'd1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkSkid("mr_drain", 1'b0, 32'h13, 2'd0, 1'b1);

    // Single-entry 7-bit stage with a scrambled out_ready pattern
    readyPat = 20'b1011_0010_1110_0101_0011;
    validPat = 20'b1111_1011_1101_1111_0111;
    expValid = 1'b0;
    expHead  = 7'h13;
    inD0     = 7'd1;
    for (int i = 0; i < 20; i++) begin
      outR0 = readyPat[i];
      inV0  = validPat[i];
      #1;
      checkOutput($sformatf("s0_ready%0d", i), {31'd0, inR0}, {31'd0, ~expValid | outR0});
      expAcc = inV0 & (~expValid | outR0);
      tick();
      if (expAcc) begin
        expValid = 1'b1;
        expHead  = inD0;
        inD0     = inD0 + 7'd1;
      end else if (expValid && outR0) begin
        expValid = 1'b0;
        expHead  = 7'h13;
      end
      checkOutput($sformatf("s0_valid%0d", i), {31'd0, outV0}, {31'd0, expValid});
      checkOutput($sformatf("s0_data%0d", i),  {25'd0, outD0}, {25'd0, expHead});
      checkOutput($sformatf("s0_count%0d", i), {30'd0, cnt0},  {31'd0, expValid});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
